// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   instr;
  } if_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  riscv_pkg::if_entry_t  push_data,
  input  logic                  pop,
  output riscv_pkg::if_entry_t  head,
  output logic                  empty,
  output logic [CW-1:0]         count
);
  import riscv_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Entry storage; a push into a full FIFO is only legal alongside a pop, so
  // the slot being written is never the one still being presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, credit-limited fetch, redirect drain
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       instruction
);
  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] last_pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic [CW:0]       outstanding_sum;
  logic [CW-1:0]     outstanding_nxt;
  logic              fifo_empty;
  logic              req_fire;
  logic              pop;
  logic              push;
  if_entry_t         head;
  if_entry_t         push_entry;
  logic              unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Every issued request owns a FIFO slot until it is popped, so the FIFO can
  // never overflow; a slot freed by this cycle's pop may be reused at once.
  assign pop             = if_valid && if_ready;
  assign credit_used     = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_valid  = reset && (state == FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;

  assign outstanding_sum = {1'b0, outstanding} + {{CW{1'b0}}, req_fire}
                         - {{CW{1'b0}}, imem_rsp_valid};
  assign outstanding_nxt = outstanding_sum[CW-1:0];

  // Responses are kept only when nothing stale is still in flight and no
  // redirect is squashing the stream this cycle.
  assign push       = imem_rsp_valid && !redirect_valid && (discard == '0);
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign if_valid    = reset && !fifo_empty;
  assign if_pc       = !reset ? RESET_PC  : (fifo_empty ? last_pc   : head.pc);
  assign instruction = !reset ? NOP_INSTR : (fifo_empty ? NOP_INSTR : head.instr);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (count)
  );

  // PC, response PC, in-flight/discard counters and the FETCH/DRAIN FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (pop) last_pc <= head.pc;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        discard  <= outstanding_nxt;
        state    <= (outstanding_nxt != '0) ? DRAIN : FETCH;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push)     rsp_pc   <= rsp_pc + ADDR_W'(4);
        if (imem_rsp_valid && (discard != '0)) begin
          discard <= discard - CW'(1);
          if (discard == CW'(1)) state <= FETCH;
        end
      end
    end
  end

  // Counter sanity: no response without a request in flight, credits bounded.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(imem_rsp_valid && (outstanding == '0)));
      assert (({1'b0, outstanding} + {1'b0, count}) <= (CW+1)'(FIFO_DEPTH));
      assert (discard <= outstanding);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] instruction;

  instr_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .instruction    (instruction)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: in-order, one response per cycle, latency drawn per request.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_ins_q[$];

  logic        s_req_valid, s_if_valid, s_acc, s_pop, s_rsp;
  logic [31:0] s_req_addr, s_if_pc, s_instr, s_pop_pc, s_pop_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive the memory response, sample at negedge+1, record.
  task automatic step();
    int d;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_instr     = instruction;
    s_acc       = imem_req_valid && imem_req_ready;
    s_pop       = if_valid && if_ready;
    s_rsp       = imem_rsp_valid;
    if (s_rsp) void'(mq.pop_front());
    if (s_acc) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: imem_req_addr, due: d});
      acc_q.push_back(imem_req_addr);
    end
    if (s_pop) begin
      s_pop_pc  = if_pc;
      s_pop_ins = instruction;
      pop_pc_q.push_back(if_pc);
      pop_ins_q.push_back(instruction);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    pop_pc_q.delete();
    pop_ins_q.delete();
    last_due = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    mq.delete();
    repeat (2) step();
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mq.delete();
    repeat (3) step();
    n_cmp++; if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", s_req_valid); end
    n_cmp++; if (s_if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %b want 0", s_if_valid); end
    n_cmp++; if (s_if_pc !== RESET_PC) begin n_bad++; $display("FAIL reset_if_pc: got %h want %h", s_if_pc, RESET_PC); end
    n_cmp++; if (s_instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", s_instr, NOP); end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
    do_reset();
    step();
    n_cmp++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin n_bad++; $display("FAIL stream_c0_req: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RESET_PC); end
    n_cmp++; if (s_if_valid !== 1'b0) begin n_bad++; $display("FAIL stream_c0_if_valid: got %b want 0", s_if_valid); end
    step();
    n_cmp++; if (s_if_valid !== 1'b0) begin n_bad++; $display("FAIL stream_c1_if_valid: got %b want 0", s_if_valid); end
    step();
    n_cmp++; if (s_if_valid !== 1'b1 || s_if_pc !== RESET_PC) begin n_bad++; $display("FAIL stream_c2_head: got v=%b pc=%h want v=1 pc=%h", s_if_valid, s_if_pc, RESET_PC); end
    repeat (20) step();
    n_cmp++; if (pop_pc_q.size() != 21) begin n_bad++; $display("FAIL stream_rate: got %0d pops want 21", pop_pc_q.size()); end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      want = RESET_PC + 32'(4 * i);
      n_cmp++;
      if (pop_pc_q[i] !== want || pop_ins_q[i] !== mem_word(want)) begin
        n_bad++; $display("FAIL stream_pop[%0d]: got pc=%h ins=%h want pc=%h ins=%h", i, pop_pc_q[i], pop_ins_q[i], want, mem_word(want));
      end
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      want = RESET_PC + 32'(4 * i);
      n_cmp++; if (acc_q[i] !== want) begin n_bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, acc_q[i], want); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
    do_reset();
    repeat (6) step();
    if_ready = 1'b0;
    repeat (5) step();
    n_cmp++; if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", s_req_valid); end
    n_cmp++; if (acc_q.size() - pop_pc_q.size() != DEPTH) begin n_bad++; $display("FAIL bp_inflight: got %0d want %0d", acc_q.size() - pop_pc_q.size(), DEPTH); end
    if_ready = 1'b1;
    repeat (10) step();
    imem_req_ready = 1'b0;
    repeat (8) step();
    n_cmp++; if (pop_pc_q.size() != acc_q.size()) begin n_bad++; $display("FAIL bp_no_loss: got %0d pops want %0d", pop_pc_q.size(), acc_q.size()); end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      want = RESET_PC + 32'(4 * i);
      n_cmp++;
      if (pop_pc_q[i] !== want || pop_ins_q[i] !== mem_word(want)) begin
        n_bad++; $display("FAIL bp_pop[%0d]: got pc=%h ins=%h want pc=%h", i, pop_pc_q[i], pop_ins_q[i], want);
      end
    end
  endtask

  task automatic test_req_toggle();
    logic [31:0] want;
    logic        prev_stall;
    logic [31:0] prev_addr;
    lat_min = 1; lat_max = 3; if_ready = 1'b1;
    do_reset();
    prev_stall = 1'b0;
    prev_addr  = '0;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = (i % 2 == 0);
      step();
      if (prev_stall && s_req_valid) begin
        n_cmp++; if (s_req_addr !== prev_addr) begin n_bad++; $display("FAIL toggle_hold: got %h want %h", s_req_addr, prev_addr); end
      end
      prev_stall = s_req_valid && !imem_req_ready;
      prev_addr  = s_req_addr;
    end
    imem_req_ready = 1'b0;
    repeat (12) step();
    n_cmp++; if (pop_pc_q.size() != acc_q.size() || acc_q.size() < 8) begin n_bad++; $display("FAIL toggle_count: got %0d pops %0d accepts", pop_pc_q.size(), acc_q.size()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      want = RESET_PC + 32'(4 * i);
      n_cmp++; if (acc_q[i] !== want) begin n_bad++; $display("FAIL toggle_addr[%0d]: got %h want %h", i, acc_q[i], want); end
    end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      want = RESET_PC + 32'(4 * i);
      n_cmp++; if (pop_pc_q[i] !== want || pop_ins_q[i] !== mem_word(want)) begin n_bad++; $display("FAIL toggle_pop[%0d]: got pc=%h want %h", i, pop_pc_q[i], want); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] want;
    int          idle;
    int          drops;
    lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_credit: got %b want 0", s_req_valid); end
    idle = 0; drops = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req_valid) break;
      idle++;
      if (s_rsp) drops++;
    end
    n_cmp++; if (idle != 2 || drops != 2) begin n_bad++; $display("FAIL redir_drain: got idle=%0d drops=%0d want 2/2", idle, drops); end
    n_cmp++; if (s_req_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL redir_addr: got %h want 00000100", s_req_addr); end
    repeat (20) step();
    imem_req_ready = 1'b0;
    repeat (10) step();
    n_cmp++; if (pop_pc_q.size() != acc_q.size() - 2 || pop_pc_q.size() == 0) begin n_bad++; $display("FAIL redir_count: got %0d pops %0d accepts", pop_pc_q.size(), acc_q.size()); end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      want = 32'h0000_0100 + 32'(4 * i);
      n_cmp++; if (pop_pc_q[i] !== want || pop_ins_q[i] !== mem_word(want)) begin n_bad++; $display("FAIL redir_pop[%0d]: got pc=%h want %h", i, pop_pc_q[i], want); end
    end
  endtask

  task automatic test_redirect_coincident();
    logic [31:0] want;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (s_acc !== 1'b1 || s_rsp !== 1'b1) begin n_bad++; $display("FAIL coin_setup: got acc=%b rsp=%b want 1/1", s_acc, s_rsp); end
    step();
    n_cmp++; if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL coin_drain: got %b want 0", s_req_valid); end
    step();
    n_cmp++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL coin_addr: got v=%b a=%h want v=1 a=00000200", s_req_valid, s_req_addr); end
    repeat (15) step();
    imem_req_ready = 1'b0;
    repeat (6) step();
    n_cmp++; if (pop_pc_q.size() != acc_q.size() - 2 || pop_pc_q.size() == 0) begin n_bad++; $display("FAIL coin_count: got %0d pops %0d accepts", pop_pc_q.size(), acc_q.size()); end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      want = 32'h0000_0200 + 32'(4 * i);
      n_cmp++; if (pop_pc_q[i] !== want || pop_ins_q[i] !== mem_word(want)) begin n_bad++; $display("FAIL coin_pop[%0d]: got pc=%h want %h", i, pop_pc_q[i], want); end
    end
  endtask

  task automatic test_random();
    logic [31:0] want;
    logic [31:0] tgt;
    logic        redir;
    int          pops;
    lat_min = 1; lat_max = 4;
    do_reset();
    want = RESET_PC;
    pops = 0;
    for (int i = 0; i < 400; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      redir          = ($urandom_range(0, 19) == 0);
      tgt            = $urandom();
      redirect_valid = redir;
      redirect_pc    = tgt;
      step();
      if (s_pop) begin
        pops++;
        n_cmp++;
        if (s_pop_pc !== want || s_pop_ins !== mem_word(want)) begin
          n_bad++; $display("FAIL rand_pop cyc %0d: got pc=%h ins=%h want pc=%h ins=%h", cyc, s_pop_pc, s_pop_ins, want, mem_word(want));
        end
        want = want + 32'd4;
      end
      if (redir) want = {tgt[31:2], 2'b00};
    end
    redirect_valid = 1'b0;
    n_cmp++; if (pops < 50) begin n_bad++; $display("FAIL rand_progress: got %0d pops want >= 50", pops); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] want;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (acc_q.size() < 4) begin
      n_bad++; $display("FAIL wrap_addr: got %0d accepts want >= 4", acc_q.size());
    end else if (acc_q[1] !== 32'hFFFF_FFF8 || acc_q[2] !== 32'hFFFF_FFFC || acc_q[3] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_addr: got %h %h %h want fffffff8 fffffffc 00000000", acc_q[1], acc_q[2], acc_q[3]);
    end
    n_cmp++;
    if (pop_pc_q.size() < 3) begin
      n_bad++; $display("FAIL wrap_pop: got %0d pops want >= 3", pop_pc_q.size());
    end else if (pop_pc_q[0] !== 32'hFFFF_FFF8 || pop_pc_q[1] !== 32'hFFFF_FFFC || pop_pc_q[2] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_pop: got %h %h %h want fffffff8 fffffffc 00000000", pop_pc_q[0], pop_pc_q[1], pop_pc_q[2]);
    end
    n_cmp++; if (s_if_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_streaming: got %b want 1", s_if_valid); end
    reset = 1'b0;
    mq.delete();
    step();
    n_cmp++; if (s_if_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_if_valid: got %b want 0", s_if_valid); end
    reset = 1'b1;
    clear_logs();
    step();
    n_cmp++; if (s_if_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_c0_if_valid: got %b want 0", s_if_valid); end
    n_cmp++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin n_bad++; $display("FAIL midreset_restart: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RESET_PC); end
    repeat (10) step();
    n_cmp++; if (pop_pc_q.size() != 9) begin n_bad++; $display("FAIL midreset_rate: got %0d pops want 9", pop_pc_q.size()); end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      want = RESET_PC + 32'(4 * i);
      n_cmp++; if (pop_pc_q[i] !== want || pop_ins_q[i] !== mem_word(want)) begin n_bad++; $display("FAIL midreset_pop[%0d]: got pc=%h want %h", i, pop_pc_q[i], want); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_req_toggle();
    test_redirect();
    test_redirect_coincident();
    test_random();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
